key_event_decoder: RTL and testbench



---
 rtl/key_event_decoder.sv | 143 ++++++++++++++
 tb/tb_key_event_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Key event decoder: turns a debounced key level into single-cycle press, short-release,
// long-press, auto-repeat and release pulses plus a registered "held" level.
module key_event_decoder #(
  parameter int unsigned CNT_W  = 26,
  parameter int unsigned T_LONG = 50_000_000,
  parameter int unsigned T_REP  = 10_000_000,
  parameter bit          REP_EN = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  typedef enum logic [1:0] {
    StArm   = 2'd0,
    StIdle  = 2'd1,
    StPress = 2'd2,
    StLong  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(T_LONG - 1);
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(T_REP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic press_q, press_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic rep_q, rep_d;
  logic rel_q, rel_d;
  logic held_q, held_d;

  // State, counter and all outputs are registered; reset clears everything into the lockout state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StArm;
      cnt_q   <= '0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      rel_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      rel_q   <= rel_d;
      held_q  <= held_d;
    end
  end

  // Next state and hold/repeat counter; release always wins over a counter terminal value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StArm: begin
        // A key held through reset must be let go before it can count as a press.
        if (!din) state_d = StIdle;
      end
      StIdle: begin
        if (din) begin
          state_d = StPress;
          cnt_d   = '0;
        end
      end
      StPress: begin
        if (!din) begin
          state_d = StIdle;
        end else if (cnt_q == LongLast) begin
          state_d = StLong;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLong: begin
        if (!din) begin
          state_d = StIdle;
        end else if (cnt_q == RepLast) begin
          // Without repeat the counter parks at its terminal value instead of wrapping.
          cnt_d = REP_EN ? '0 : cnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StArm;
        cnt_d   = '0;
      end
    endcase
  end

  // Next values of the registered event pulses and the held level.
  always_comb begin
    press_d = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      StIdle: begin
        press_d = din;
      end
      StPress: begin
        if (!din) begin
          short_d = 1'b1;
          rel_d   = 1'b1;
        end else if (cnt_q == LongLast) begin
          long_d = 1'b1;
        end
      end
      StLong: begin
        if (!din) begin
          rel_d = 1'b1;
        end else if (REP_EN && (cnt_q == RepLast)) begin
          rep_d = 1'b1;
        end
      end
      default: ;
    endcase
    held_d = (state_d == StPress) || (state_d == StLong);
  end

  assign press_pulse   = press_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_q;
  assign release_pulse = rel_q;
  assign held          = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: one instance with auto-repeat, one without.
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic n_rst;
  logic din;
  always #5 clk = ~clk;

  logic pa, sa, la, ra, rla, ha;
  logic pb, sb, lb, rb, rlb, hb;
  logic [5:0] out_a, out_b; // {press, short, long, repeat, release, held}
  assign out_a = {pa, sa, la, ra, rla, ha};
  assign out_b = {pb, sb, lb, rb, rlb, hb};

  key_event_decoder #(.CNT_W(8), .T_LONG(10), .T_REP(4), .REP_EN(1'b1)) dut_rep (
    .clk(clk), .n_rst(n_rst), .din(din),
    .press_pulse(pa), .short_pulse(sa), .long_pulse(la), .repeat_pulse(ra),
    .release_pulse(rla), .held(ha)
  );

  key_event_decoder #(.CNT_W(8), .T_LONG(10), .T_REP(4), .REP_EN(1'b0)) dut_norep (
    .clk(clk), .n_rst(n_rst), .din(din),
    .press_pulse(pb), .short_pulse(sb), .long_pulse(lb), .repeat_pulse(rb),
    .release_pulse(rlb), .held(hb)
  );

  int checks = 0;
  int errors = 0;

  // Per-edge pulse history, bit i = output seen after edge E0+i.
  logic [63:0] m_press, m_short, m_long, m_rep, m_rel, m_held;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold din for n_high edges starting at E0, then release and watch a few idle edges.
  task automatic run_hold(input int n_high, input bit sel_norep);
    logic [5:0] o;
    m_press = '0; m_short = '0; m_long = '0; m_rep = '0; m_rel = '0; m_held = '0;
    for (int i = 0; i < n_high + 4; i++) begin
      din = (i < n_high);
      tick();
      o = sel_norep ? out_b : out_a;
      m_press[i] = o[5]; m_short[i] = o[4]; m_long[i] = o[3];
      m_rep[i] = o[2]; m_rel[i] = o[1]; m_held[i] = o[0];
    end
    din = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    din   = 1'b0;
    tick();
    tick();
    checks++; if (out_a !== 6'b0) begin errors++;
      $display("FAIL reset_a got %b want %b", out_a, 6'b0); end
    checks++; if (out_b !== 6'b0) begin errors++;
      $display("FAIL reset_b got %b want %b", out_b, 6'b0); end
    n_rst = 1'b1;
    tick();
    tick();
    checks++; if (out_a !== 6'b0) begin errors++;
      $display("FAIL post_reset_idle got %b want %b", out_a, 6'b0); end
  endtask

  task automatic test_short_press();
    run_hold(3, 1'b0);
    checks++; if (m_press !== 64'h1) begin errors++;
      $display("FAIL short3_press got %h want %h", m_press, 64'h1); end
    checks++; if (m_short !== 64'h8) begin errors++;
      $display("FAIL short3_short got %h want %h", m_short, 64'h8); end
    checks++; if (m_rel !== 64'h8) begin errors++;
      $display("FAIL short3_release got %h want %h", m_rel, 64'h8); end
    checks++; if (m_held !== 64'h7) begin errors++;
      $display("FAIL short3_held got %h want %h", m_held, 64'h7); end
    checks++; if ((m_long | m_rep) !== 64'h0) begin errors++;
      $display("FAIL short3_nolong got %h want %h", m_long | m_rep, 64'h0); end
  endtask

  task automatic test_long_repeat();
    run_hold(20, 1'b0);
    checks++; if (m_press !== 64'h1) begin errors++;
      $display("FAIL long20_press got %h want %h", m_press, 64'h1); end
    checks++; if (m_long !== 64'h400) begin errors++;
      $display("FAIL long20_long got %h want %h", m_long, 64'h400); end
    checks++; if (m_rep !== 64'h44000) begin errors++;
      $display("FAIL long20_repeat got %h want %h", m_rep, 64'h44000); end
    checks++; if (m_rel !== 64'h100000) begin errors++;
      $display("FAIL long20_release got %h want %h", m_rel, 64'h100000); end
    checks++; if (m_short !== 64'h0) begin errors++;
      $display("FAIL long20_noshort got %h want %h", m_short, 64'h0); end
    checks++; if (m_held !== 64'hFFFFF) begin errors++;
      $display("FAIL long20_held got %h want %h", m_held, 64'hFFFFF); end
  endtask

  task automatic test_release_priority();
    // din drops on the edge where cnt = 9 (E0+10).
    run_hold(10, 1'b0);
    checks++; if (m_long !== 64'h0) begin errors++;
      $display("FAIL edge9_nolong got %h want %h", m_long, 64'h0); end
    checks++; if (m_short !== 64'h400) begin errors++;
      $display("FAIL edge9_short got %h want %h", m_short, 64'h400); end
    checks++; if (m_rel !== 64'h400) begin errors++;
      $display("FAIL edge9_release got %h want %h", m_rel, 64'h400); end
    checks++; if (m_held !== 64'h3FF) begin errors++;
      $display("FAIL edge9_held got %h want %h", m_held, 64'h3FF); end
  endtask

  task automatic test_no_repeat();
    run_hold(30, 1'b1);
    checks++; if (m_long !== 64'h400) begin errors++;
      $display("FAIL norep_long got %h want %h", m_long, 64'h400); end
    checks++; if (m_rep !== 64'h0) begin errors++;
      $display("FAIL norep_repeat got %h want %h", m_rep, 64'h0); end
    checks++; if (m_rel !== 64'h40000000) begin errors++;
      $display("FAIL norep_release got %h want %h", m_rel, 64'h40000000); end
    checks++; if (m_held !== 64'h3FFFFFFF) begin errors++;
      $display("FAIL norep_held got %h want %h", m_held, 64'h3FFFFFFF); end
  endtask

  task automatic test_arm_lockout();
    logic [5:0] any;
    n_rst = 1'b0;
    din   = 1'b1;
    tick();
    n_rst = 1'b1;
    any   = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      any = any | out_a | out_b;
    end
    checks++; if (any !== 6'b0) begin errors++;
      $display("FAIL arm_quiet got %b want %b", any, 6'b0); end
    din = 1'b0;
    tick();
    checks++; if (out_a !== 6'b0) begin errors++;
      $display("FAIL arm_release_silent got %b want %b", out_a, 6'b0); end
    din = 1'b1;
    tick();
    checks++; if (out_a !== 6'b100001) begin errors++;
      $display("FAIL arm_repress got %b want %b", out_a, 6'b100001); end
    din = 1'b0;
    tick();
    checks++; if (out_b !== 6'b010010) begin errors++;
      $display("FAIL arm_min_release got %b want %b", out_b, 6'b010010); end
    tick();
  endtask

  task automatic test_back_to_back();
    din = 1'b1;
    tick();
    checks++; if (out_a !== 6'b100001) begin errors++;
      $display("FAIL b2b_press1 got %b want %b", out_a, 6'b100001); end
    din = 1'b0;
    tick();
    checks++; if (out_a !== 6'b010010) begin errors++;
      $display("FAIL b2b_release1 got %b want %b", out_a, 6'b010010); end
    din = 1'b1;
    tick();
    checks++; if (out_a !== 6'b100001) begin errors++;
      $display("FAIL b2b_press2 got %b want %b", out_a, 6'b100001); end
    din = 1'b0;
    tick();
    checks++; if (out_a !== 6'b010010) begin errors++;
      $display("FAIL b2b_release2 got %b want %b", out_a, 6'b010010); end
    tick();
    checks++; if (out_a !== 6'b0) begin errors++;
      $display("FAIL b2b_idle got %b want %b", out_a, 6'b0); end
  endtask

  task automatic test_reset_in_long();
    logic [5:0] any;
    din = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    checks++; if (out_a !== 6'b001001) begin errors++;
      $display("FAIL rstlong_long got %b want %b", out_a, 6'b001001); end
    n_rst = 1'b0;
    #1;
    checks++; if (out_a !== 6'b0) begin errors++;
      $display("FAIL rstlong_clear_a got %b want %b", out_a, 6'b0); end
    checks++; if (out_b !== 6'b0) begin errors++;
      $display("FAIL rstlong_clear_b got %b want %b", out_b, 6'b0); end
    tick();
    n_rst = 1'b1;
    any   = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any = any | out_a | out_b;
    end
    checks++; if (any !== 6'b0) begin errors++;
      $display("FAIL rstlong_quiet got %b want %b", any, 6'b0); end
    din = 1'b0;
    tick();
    din = 1'b1;
    tick();
    checks++; if (out_a !== 6'b100001) begin errors++;
      $display("FAIL rstlong_repress got %b want %b", out_a, 6'b100001); end
    din = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_priority();
    test_no_repeat();
    test_arm_lockout();
    test_back_to_back();
    test_reset_in_long();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
